// File: rtl/dsp_dot_pkg.sv
// Shared types and default widths for the dot-product operand sequencer.
package dsp_dot_pkg;

    localparam int DEF_A_W   = 18;
    localparam int DEF_B_W   = 18;
    localparam int DEF_P_W   = 40;
    localparam int DEF_LEN_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_DRAIN,
        ST_HOLD
    } state_e;

    // Per-term token travelling alongside the slice pipeline.
    typedef struct packed {
        logic fdbk;
    } tok_t;

endpackage

// File: rtl/dsp_dot_tokpipe.sv
// Fixed-depth valid+payload delay line with synchronous clear; busy flags any
// token still in flight.
module dsp_dot_tokpipe #(
    parameter int STAGES = 1,
    parameter int W      = 1
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic         busy
);

    logic [STAGES-1:0] vld_reg;
    logic [W-1:0]      dat_reg [STAGES];

    always_ff @(posedge clk) begin
        if (srst) begin
            vld_reg <= '0;
            for (int i = 0; i < STAGES; i++) dat_reg[i] <= '0;
        end else begin
            for (int i = STAGES - 1; i > 0; i--) begin
                vld_reg[i] <= vld_reg[i-1];
                dat_reg[i] <= dat_reg[i-1];
            end
            vld_reg[0] <= in_valid;
            dat_reg[0] <= in_data;
        end
    end

    assign out_valid = vld_reg[STAGES-1];
    assign out_data  = dat_reg[STAGES-1];
    assign busy      = |vld_reg;

endmodule

// File: rtl/dsp_dot_seq.sv
// Operand sequencer for a MAC slice in feedback mode: streams (a,b) terms into
// the slice and returns each vector's dot product. Optional DSP_DOT_OVF_EN
// force-terminates a vector when the term counter reaches its maximum.
module dsp_dot_seq
    import dsp_dot_pkg::*;
#(
    parameter int A_W   = DEF_A_W,
    parameter int B_W   = DEF_B_W,
    parameter int P_W   = DEF_P_W,
    parameter int LEN_W = DEF_LEN_W,
    parameter int LAT   = 2
) (
    input  logic             CLK,
    input  logic             SRST,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [A_W-1:0]   s_a,
    input  logic [B_W-1:0]   s_b,
    input  logic             s_last,
    output logic [A_W-1:0]   dsp_a,
    output logic [B_W-1:0]   dsp_b,
    output logic             dsp_in_en,
    output logic             dsp_p_en,
    output logic             dsp_fdbk_sel,
    input  logic [P_W-1:0]   dsp_p,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [P_W-1:0]   m_data,
    output logic [LEN_W-1:0] m_count,
    output logic             m_ovf
);

    state_e           state_reg, state_next;
    logic [LEN_W-1:0] cnt_reg, cnt_next;
    tok_t             tok_reg;
    logic             accept, first_beat, forced, last_beat;
    logic             pipe_valid, pipe_busy, busy, capture;
    logic [0:0]       pipe_data;

    assign s_ready    = !SRST && (state_reg == ST_IDLE || state_reg == ST_ACCUM);
    assign accept     = s_valid && s_ready;
    assign first_beat = (state_reg == ST_IDLE);
    assign cnt_next   = first_beat ? LEN_W'(1) : cnt_reg + LEN_W'(1);

`ifdef DSP_DOT_OVF_EN
    assign forced = (cnt_next == {LEN_W{1'b1}}) && !s_last;
`else
    assign forced = 1'b0;
`endif
    assign last_beat = s_last || forced;

    // Tokens in the input register stage or the delay line mean P is not final yet.
    assign busy    = dsp_in_en || pipe_busy;
    assign capture = (state_reg == ST_DRAIN) && !busy;
    assign m_valid = (state_reg == ST_HOLD);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (accept) state_next = last_beat ? ST_DRAIN : ST_ACCUM;
            ST_ACCUM: if (accept && last_beat) state_next = ST_DRAIN;
            ST_DRAIN: if (!busy) state_next = ST_HOLD;
            ST_HOLD:  if (m_ready) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (SRST) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            tok_reg   <= '0;
            dsp_a     <= '0;
            dsp_b     <= '0;
            dsp_in_en <= 1'b0;
            m_data    <= '0;
            m_count   <= '0;
        end else begin
            state_reg <= state_next;
            dsp_in_en <= accept;
            if (accept) begin
                dsp_a        <= s_a;
                dsp_b        <= s_b;
                tok_reg.fdbk <= !first_beat;
                cnt_reg      <= cnt_next;
            end
            if (capture) begin
                m_data  <= dsp_p;
                m_count <= cnt_reg;
            end
        end
    end

`ifdef DSP_DOT_OVF_EN
    logic ovf_reg;

    always_ff @(posedge CLK) begin
        if (SRST) begin
            ovf_reg <= 1'b0;
            m_ovf   <= 1'b0;
        end else begin
            if (accept && (first_beat || forced)) ovf_reg <= forced;
            if (capture) m_ovf <= ovf_reg;
        end
    end
`else
    assign m_ovf = 1'b0;
`endif

    // Token enters alongside dsp_in_en so it exits exactly when P must update.
    dsp_dot_tokpipe #(
        .STAGES (LAT - 1),
        .W      (1)
    ) u_tokpipe (
        .clk       (CLK),
        .srst      (SRST),
        .in_valid  (dsp_in_en),
        .in_data   (tok_reg),
        .out_valid (pipe_valid),
        .out_data  (pipe_data),
        .busy      (pipe_busy)
    );

    assign dsp_p_en     = pipe_valid;
    assign dsp_fdbk_sel = pipe_valid & pipe_data[0];

endmodule

// File: tb/tb_dsp_dot_seq.sv
// Scoreboard bench for dsp_dot_seq with a behavioural MACC slice on the dsp_* ports.
module tb_dsp_dot_seq;

    localparam int A_W = 18;
    localparam int B_W = 18;
    localparam int P_W = 40;
    localparam int LAT = 2;
`ifdef DSP_DOT_OVF_EN
    localparam int LEN_W = 2;
`else
    localparam int LEN_W = 8;
`endif

    logic             CLK = 1'b0;
    logic             SRST;
    logic             s_valid, s_ready, s_last;
    logic [A_W-1:0]   s_a;
    logic [B_W-1:0]   s_b;
    logic [A_W-1:0]   dsp_a;
    logic [B_W-1:0]   dsp_b;
    logic             dsp_in_en, dsp_p_en, dsp_fdbk_sel;
    logic [P_W-1:0]   dsp_p;
    logic             m_valid, m_ready, m_ovf;
    logic [P_W-1:0]   m_data;
    logic [LEN_W-1:0] m_count;

    dsp_dot_seq #(.A_W(A_W), .B_W(B_W), .P_W(P_W), .LEN_W(LEN_W), .LAT(LAT)) dut (
        .CLK(CLK), .SRST(SRST),
        .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b), .s_last(s_last),
        .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_in_en(dsp_in_en), .dsp_p_en(dsp_p_en),
        .dsp_fdbk_sel(dsp_fdbk_sel), .dsp_p(dsp_p),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_count(m_count), .m_ovf(m_ovf)
    );

    always #5 CLK = ~CLK;

    // Behavioural slice for LAT=2: A/B input registers, then P load/accumulate.
    logic signed [A_W-1:0] a_r = '0;
    logic signed [B_W-1:0] b_r = '0;
    logic signed [P_W-1:0] p_r = '0;
    logic signed [P_W-1:0] prod;
    assign prod  = a_r * b_r;
    assign dsp_p = p_r;
    always @(posedge CLK) begin
        if (dsp_in_en) begin
            a_r <= dsp_a;
            b_r <= dsp_b;
        end
        if (dsp_p_en) p_r <= (dsp_fdbk_sel ? p_r : '0) + prod;
    end

    typedef struct {
        logic [P_W-1:0]   data;
        logic [LEN_W-1:0] cnt;
        logic             ovf;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   last_acc = 0;
    bit   checking = 0;
    bit   cur_first = 0;
    bit   mv_prev = 0;
    bit   h_acc[LAT];
    bit   h_first[LAT];
    logic [P_W-1:0]   hold_data;
    logic [LEN_W-1:0] hold_cnt;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input longint d, input int c, input bit o);
        exp_t e;
        e.data = P_W'(d);
        e.cnt  = LEN_W'(c);
        e.ovf  = o;
        sbq.push_back(e);
    endtask

    // Presents one term and returns right after the handshake edge.
    task automatic send(input int a, input int b, input bit last, input bit first);
        int w = 0;
        s_valid = 1'b1; s_a = A_W'(a); s_b = B_W'(b); s_last = last; cur_first = first;
        forever begin
            @(negedge CLK);
            if (s_ready) break;
            w++;
            if (w > 200) begin
                n_tests++; n_fail++;
                $display("FAIL send_timeout: s_ready stayed 0 for %0d cycles, required 1", w);
                break;
            end
        end
        @(posedge CLK); #1;
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 300 && sbq.size() != 0; i++) @(posedge CLK);
        if (sbq.size() != 0) begin
            n_tests++; n_fail++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", sbq.size());
            sbq.delete();
        end
        idle(2);
    endtask

    // Monitor: per-cycle strobe checks plus scoreboard pops on result handshakes.
    always @(negedge CLK) begin
        if (checking) begin
            chk("dsp_in_en", 64'(dsp_in_en), 64'(h_acc[0]));
            chk("dsp_p_en", 64'(dsp_p_en), 64'(h_acc[LAT-1]));
            if (dsp_p_en) chk("dsp_fdbk_sel", 64'(dsp_fdbk_sel), 64'(!h_first[LAT-1]));
            if (m_valid) chk("s_ready_hold", 64'(s_ready), 64'(0));
            if (m_valid && !mv_prev) begin
                chk("m_valid_latency", 64'(cyc - last_acc), 64'(LAT + 2));
                hold_data = m_data;
                hold_cnt  = m_count;
            end else if (m_valid) begin
                chk("m_data_stable", 64'(m_data), 64'(hold_data));
                chk("m_count_stable", 64'(m_count), 64'(hold_cnt));
            end
            if (m_valid && m_ready) begin
                if (sbq.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_result: got m_data 0x%0h, required no result", m_data);
                end else begin
                    mon_e = sbq.pop_front();
                    chk("m_data", 64'(m_data), 64'(mon_e.data));
                    chk("m_count", 64'(m_count), 64'(mon_e.cnt));
                    chk("m_ovf", 64'(m_ovf), 64'(mon_e.ovf));
                end
            end
        end
        for (int k = LAT - 1; k > 0; k--) begin
            h_acc[k]   = h_acc[k-1];
            h_first[k] = h_first[k-1];
        end
        h_acc[0]   = s_valid && s_ready;
        h_first[0] = cur_first;
        if (SRST) begin
            for (int k = 0; k < LAT; k++) begin
                h_acc[k] = 1'b0;
                h_first[k] = 1'b0;
            end
        end
        if (s_valid && s_ready) last_acc = cyc;
        mv_prev = m_valid;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        SRST = 1'b1; s_valid = 1'b0; s_a = '0; s_b = '0; s_last = 1'b0; m_ready = 1'b1;
        for (int k = 0; k < LAT; k++) begin h_acc[k] = 1'b0; h_first[k] = 1'b0; end
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_s_ready_in_reset", 64'(s_ready), 64'(0));
        @(posedge CLK); #1;
        SRST = 1'b0;
        @(negedge CLK);
        chk("rst_s_ready", 64'(s_ready), 64'(1));
        chk("rst_dsp_a", 64'(dsp_a), 64'(0));
        chk("rst_dsp_b", 64'(dsp_b), 64'(0));
        chk("rst_dsp_in_en", 64'(dsp_in_en), 64'(0));
        chk("rst_dsp_p_en", 64'(dsp_p_en), 64'(0));
        chk("rst_dsp_fdbk_sel", 64'(dsp_fdbk_sel), 64'(0));
        chk("rst_m_valid", 64'(m_valid), 64'(0));
        chk("rst_m_data", 64'(m_data), 64'(0));
        chk("rst_m_count", 64'(m_count), 64'(0));
        chk("rst_m_ovf", 64'(m_ovf), 64'(0));
        checking = 1'b1;
        idle(1);

        // 3*4 + 5*-2 + -1*7 = -5
        push_exp(-5, 3, 0);
        send(3, 4, 0, 1); send(5, -2, 0, 0); send(-1, 7, 1, 0);
        wait_drain();

        // (-2^17)^2 = 2^34
        push_exp(64'd17179869184, 1, 0);
        send(-131072, -131072, 1, 1);
        wait_drain();

        // Back-to-back: 1*2+3*4 = 14, then 10*10 + 2*-3 = 94 with a 10-cycle stall
        m_ready = 1'b0;
        push_exp(14, 2, 0);
        push_exp(94, 2, 0);
        fork
            begin
                send(1, 2, 0, 1); send(3, 4, 1, 0);
                send(10, 10, 0, 1); send(2, -3, 1, 0);
            end
            begin
                for (int i = 0; i < 100 && !m_valid; i++) @(negedge CLK);
                repeat (10) @(posedge CLK);
                #1 m_ready = 1'b1;
            end
        join
        wait_drain();

        // Gapped stream gives the same -5
        push_exp(-5, 3, 0);
        send(3, 4, 0, 1); idle(1); send(5, -2, 0, 0); idle(1); send(-1, 7, 1, 0);
        wait_drain();

        // Reset after two terms; partial sum discarded, then 2*3 = 6
        send(1, 1, 0, 1); send(2, 2, 0, 0);
        SRST = 1'b1;
        @(posedge CLK); #1;
        SRST = 1'b0;
        idle(3);
        push_exp(6, 1, 0);
        send(2, 3, 1, 1);
        wait_drain();

`ifdef DSP_DOT_OVF_EN
        // Counter saturates at 3: third unterminated term forces the result
        push_exp(3, 3, 1);
        push_exp(2, 2, 0);
        send(1, 1, 0, 1); send(1, 1, 0, 0); send(1, 1, 0, 0);
        send(1, 1, 0, 1); send(1, 1, 1, 0);
        wait_drain();
`endif

        checking = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
